// File: rtl/lock_pkg.sv
// lock_pkg: shared state encoding and BCD constants for the digital lock controller
package lock_pkg;
  typedef enum logic [2:0] {IDLE, ENTRY, CHECK, UNLOCKED, PROG, LOCKOUT} state_t;
  localparam int BCD_W = 4;
  localparam int BCD_MAX = 9;
endpackage

// File: rtl/lock_timer.sv
// lock_timer: loadable down-counter that stops at zero and flags it
// Ports:
//   i_clk   clock, rising edge
//   i_rst_n asynchronous active-low reset, clears the count
//   i_load  load i_val this cycle (wins over counting)
//   i_val   value to load
//   o_zero  high while the count is zero
module lock_timer #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_zero
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_cnt <= '0;
    else r_cnt <= i_load ? i_val : (r_cnt == '0 ? r_cnt : r_cnt - W'(1));
  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/pass_security_ctrl.sv
// pass_security_ctrl: password check controller with runtime reprogramming, entry timeout and escalating lockout
// Ports:
//   i_clk           clock, rising edge
//   i_lock_rst_n    asynchronous active-low reset (released synchronously inside)
//   i_mode          0 = relock on a press while unlocked, 1 = program a new password
//   i_digit_in      BCD digit sampled on a press; values above 9 are ignored
//   i_enter         press request level; a rising edge is one press
//   o_unlocked      high while unlocked
//   o_alarm         high while locked out
//   o_fail_cnt      consecutive failed entries
//   o_digit_idx     digits captured in the current entry
//   o_lock_level    lockout escalation level
//   o_pass_changed  one-cycle pulse when a new password is stored
module pass_security_ctrl
  import lock_pkg::*;
#(
  parameter int                       DIGITS         = 4,
  parameter logic [DIGITS*BCD_W-1:0] DEFAULT_PASS   = 16'h1234,
  parameter int                       MAX_TRIES      = 3,
  parameter int                       LOCKOUT_CYCLES = 100,
  parameter int                       MAX_LEVEL      = 2,
  parameter int                       TIMEOUT_CYCLES = 50
) (
  input  logic                             i_clk,
  input  logic                             i_lock_rst_n,
  input  logic                             i_mode,
  input  logic [BCD_W-1:0]                 i_digit_in,
  input  logic                             i_enter,
  output logic                             o_unlocked,
  output logic                             o_alarm,
  output logic [$clog2(MAX_TRIES+1)-1:0]   o_fail_cnt,
  output logic [$clog2(DIGITS+1)-1:0]      o_digit_idx,
  output logic [$clog2(MAX_LEVEL+1)-1:0]   o_lock_level,
  output logic                             o_pass_changed
);
  localparam int FW = $clog2(MAX_TRIES+1);
  localparam int IW = $clog2(DIGITS+1);
  localparam int LW = $clog2(MAX_LEVEL+1);
  localparam int EW = $clog2(TIMEOUT_CYCLES+1);
  localparam int TW = $clog2((LOCKOUT_CYCLES << MAX_LEVEL)+1);
  localparam int PW = DIGITS*BCD_W;

  state_t          r_state, w_state_nxt;
  logic [1:0]      r_rst_sync;
  logic            w_rst_n;
  logic            r_enter_d;
  logic [PW-1:0]   r_buf, r_pass, w_buf_nxt;
  logic [IW-1:0]   r_idx, w_idx_nxt;
  logic [FW-1:0]   r_fail, w_fail_nxt, w_fail_inc;
  logic [LW-1:0]   r_level, w_level_nxt;
  logic            r_pass_changed;
  logic            w_press, w_valid, w_last, w_match;
  logic            w_store, w_prog_done, w_tload, w_lload, w_tzero, w_lzero;
  logic [TW-1:0]   w_lock_len;

  // reset asserts asynchronously, releases two clocks after i_lock_rst_n rises
  always_ff @(posedge i_clk or negedge i_lock_rst_n)
    if (!i_lock_rst_n) r_rst_sync <= 2'b00;
    else r_rst_sync <= {r_rst_sync[0], 1'b1};
  assign w_rst_n = r_rst_sync[1];

  assign w_press    = i_enter & ~r_enter_d;
  assign w_valid    = w_press & (i_digit_in <= BCD_W'(BCD_MAX));
  assign w_last     = (r_idx == IW'(DIGITS-1));
  assign w_match    = (r_buf == r_pass);
  assign w_fail_inc = r_fail + FW'(1);
  // timers load N-1 so that exactly N cycles elapse before the zero flag acts
  assign w_lock_len = TW'((LOCKOUT_CYCLES << r_level) - 1);

  // buffer with the current digit placed in slot r_idx; slot 0 sits in the MSBs
  always_comb begin
    w_buf_nxt = r_buf;
    for (int i = 0; i < DIGITS; i++)
      if (r_idx == IW'(i)) w_buf_nxt[(DIGITS-1-i)*BCD_W +: BCD_W] = i_digit_in;
  end

  lock_timer #(.W(EW)) u_entry_timer (
    .i_clk   (i_clk),
    .i_rst_n (w_rst_n),
    .i_load  (w_tload),
    .i_val   (EW'(TIMEOUT_CYCLES-1)),
    .o_zero  (w_tzero)
  );

  lock_timer #(.W(TW)) u_lock_timer (
    .i_clk   (i_clk),
    .i_rst_n (w_rst_n),
    .i_load  (w_lload),
    .i_val   (w_lock_len),
    .o_zero  (w_lzero)
  );

  always_ff @(posedge i_clk or negedge w_rst_n)
    if (!w_rst_n) r_state <= IDLE;
    else r_state <= w_state_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_fail_nxt  = r_fail;
    w_level_nxt = r_level;
    w_store     = 1'b0;
    w_prog_done = 1'b0;
    w_tload     = 1'b0;
    w_lload     = 1'b0;
    case (r_state)
      IDLE, ENTRY: begin
        if (w_valid) begin
          w_store     = 1'b1;
          w_tload     = 1'b1;
          w_idx_nxt   = r_idx + IW'(1);
          w_state_nxt = w_last ? CHECK : ENTRY;
        end else if (r_state == ENTRY && w_tzero) begin
          w_idx_nxt   = '0;
          w_state_nxt = IDLE;
        end
      end
      CHECK: begin
        w_idx_nxt = '0;
        if (w_match) begin
          w_state_nxt = UNLOCKED;
          w_fail_nxt  = '0;
          w_level_nxt = '0;
        end else begin
          w_fail_nxt  = w_fail_inc;
          w_lload     = (w_fail_inc == FW'(MAX_TRIES));
          w_state_nxt = w_lload ? LOCKOUT : IDLE;
        end
      end
      UNLOCKED: begin
        if (w_valid) begin
          w_state_nxt = i_mode ? PROG : IDLE;
          w_tload     = i_mode;
        end
      end
      PROG: begin
        if (w_valid) begin
          w_store     = 1'b1;
          w_tload     = 1'b1;
          w_prog_done = w_last;
          w_idx_nxt   = w_last ? '0 : r_idx + IW'(1);
          w_state_nxt = w_last ? IDLE : PROG;
        end else if (w_tzero) begin
          w_idx_nxt   = '0;
          w_state_nxt = UNLOCKED;
        end
      end
      LOCKOUT: begin
        if (w_lzero) begin
          w_state_nxt = IDLE;
          w_fail_nxt  = '0;
          w_level_nxt = (r_level == LW'(MAX_LEVEL)) ? r_level : r_level + LW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge w_rst_n)
    if (!w_rst_n) begin
      r_enter_d      <= 1'b0;
      r_buf          <= '0;
      r_pass         <= DEFAULT_PASS;
      r_idx          <= '0;
      r_fail         <= '0;
      r_level        <= '0;
      r_pass_changed <= 1'b0;
    end else begin
      r_enter_d      <= i_enter;
      r_idx          <= w_idx_nxt;
      r_fail         <= w_fail_nxt;
      r_level        <= w_level_nxt;
      r_pass_changed <= w_prog_done;
      if (w_store) r_buf <= w_buf_nxt;
      if (w_prog_done) r_pass <= w_buf_nxt;
    end

  assign o_unlocked     = (r_state == UNLOCKED);
  assign o_alarm        = (r_state == LOCKOUT);
  assign o_fail_cnt     = r_fail;
  assign o_digit_idx    = r_idx;
  assign o_lock_level   = r_level;
  assign o_pass_changed = r_pass_changed;
endmodule

// File: tb/tb_pass_security_ctrl.sv
// tb_pass_security_ctrl: randomized self-checking bench for pass_security_ctrl against a transaction-level lock model
module tb_pass_security_ctrl;
  localparam int DIGITS = 4;
  localparam int MAX_TRIES = 3;
  localparam int LOCKOUT_CYCLES = 100;
  localparam int MAX_LEVEL = 2;
  localparam int TIMEOUT_CYCLES = 50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       mode = 1'b0;
  logic       enter = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       unlocked, alarm, pass_changed;
  logic [1:0] fail_cnt, lock_level;
  logic [2:0] digit_idx;

  int checks = 0;
  int failures = 0;
  logic [15:0] m_pass = 16'h1234;
  int m_fail = 0;
  int m_level = 0;

  always #5 clk = ~clk;

  pass_security_ctrl #(
    .DIGITS(DIGITS), .DEFAULT_PASS(16'h1234), .MAX_TRIES(MAX_TRIES),
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES), .MAX_LEVEL(MAX_LEVEL), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .i_clk(clk), .i_lock_rst_n(rst_n), .i_mode(mode), .i_digit_in(digit), .i_enter(enter),
    .o_unlocked(unlocked), .o_alarm(alarm), .o_fail_cnt(fail_cnt), .o_digit_idx(digit_idx),
    .o_lock_level(lock_level), .o_pass_changed(pass_changed)
  );

  function automatic logic [15:0] rand_code();
    logic [15:0] c;
    for (int i = 0; i < DIGITS; i++) c[i*4 +: 4] = 4'($urandom_range(0, 9));
    return c;
  endfunction

  function automatic logic [15:0] wrong_code();
    logic [15:0] c;
    c = rand_code();
    if (c == m_pass) c[3:0] = (c[3:0] == 4'd9) ? 4'd0 : c[3:0] + 4'd1;
    return c;
  endfunction

  task automatic press(input logic [3:0] d, input logic md, input int hold);
    @(negedge clk);
    enter = 1'b1;
    digit = d;
    mode = md;
    repeat (hold) @(negedge clk);
    enter = 1'b0;
    digit = 4'($urandom_range(0, 15));
  endtask

  task automatic enter_code(input logic [15:0] code);
    for (int i = 0; i < DIGITS; i++) begin
      if ($urandom_range(0, 3) == 0) press(4'($urandom_range(10, 15)), 1'b0, 1);
      press(code[(DIGITS-1-i)*4 +: 4], 1'b0, (i == DIGITS-1) ? 1 : $urandom_range(1, 3));
      if (i < DIGITS-1) begin
        checks++; if (digit_idx !== 3'(i+1)) begin failures++; $display("FAIL digit_idx_progress got=%0d exp=%0d", digit_idx, i+1); end
        repeat ($urandom_range(0, 4)) @(negedge clk);
      end
    end
  endtask

  // called half a cycle after the last digit's press edge, i.e. during the CHECK cycle
  task automatic finish_entry(input logic [15:0] code);
    int len, n;
    checks++; if (unlocked !== 1'b0 || alarm !== 1'b0) begin failures++; $display("FAIL check_cycle_quiet got=%0b%0b exp=00", unlocked, alarm); end
    @(negedge clk);
    if (code == m_pass) begin
      m_fail = 0;
      m_level = 0;
      checks++; if (unlocked !== 1'b1) begin failures++; $display("FAIL unlock got=%0b exp=1 code=%h", unlocked, code); end
      checks++; if (fail_cnt !== 2'd0 || lock_level !== 2'd0) begin failures++; $display("FAIL unlock_clears got=%0d/%0d exp=0/0", fail_cnt, lock_level); end
    end else begin
      m_fail++;
      checks++; if (unlocked !== 1'b0) begin failures++; $display("FAIL wrong_stays_locked got=%0b exp=0 code=%h", unlocked, code); end
      checks++; if (fail_cnt !== 2'(m_fail)) begin failures++; $display("FAIL fail_cnt got=%0d exp=%0d", fail_cnt, m_fail); end
      if (m_fail == MAX_TRIES) begin
        len = LOCKOUT_CYCLES << m_level;
        n = 0;
        while (alarm === 1'b1 && n < 2000) begin
          n++;
          enter = 1'($urandom_range(0, 1));
          digit = 4'($urandom_range(0, 15));
          mode = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
        enter = 1'b0;
        m_fail = 0;
        m_level = (m_level == MAX_LEVEL) ? m_level : m_level + 1;
        checks++; if (n !== len) begin failures++; $display("FAIL alarm_length got=%0d exp=%0d", n, len); end
        checks++; if (fail_cnt !== 2'd0 || lock_level !== 2'(m_level)) begin failures++; $display("FAIL after_lockout got=%0d/%0d exp=0/%0d", fail_cnt, lock_level, m_level); end
        checks++; if (digit_idx !== 3'd0 || unlocked !== 1'b0) begin failures++; $display("FAIL lockout_presses_ignored got=%0d/%0b exp=0/0", digit_idx, unlocked); end
      end else begin
        checks++; if (alarm !== 1'b0 || digit_idx !== 3'd0) begin failures++; $display("FAIL wrong_to_idle got=%0b/%0d exp=0/0", alarm, digit_idx); end
      end
    end
  endtask

  task automatic unlock_correct();
    enter_code(m_pass);
    finish_entry(m_pass);
  endtask

  task automatic relock();
    press(4'($urandom_range(0, 9)), 1'b0, 1);
    checks++; if (unlocked !== 1'b0) begin failures++; $display("FAIL relock got=%0b exp=0", unlocked); end
  endtask

  task automatic program_pass(input logic [15:0] p);
    press(4'($urandom_range(0, 9)), 1'b1, 1);
    checks++; if (unlocked !== 1'b0 || digit_idx !== 3'd0) begin failures++; $display("FAIL enter_prog got=%0b/%0d exp=0/0", unlocked, digit_idx); end
    enter_code(p);
    checks++; if (pass_changed !== 1'b1 || unlocked !== 1'b0) begin failures++; $display("FAIL pass_changed_pulse got=%0b/%0b exp=1/0", pass_changed, unlocked); end
    @(negedge clk);
    checks++; if (pass_changed !== 1'b0) begin failures++; $display("FAIL pass_changed_width got=%0b exp=0", pass_changed); end
    m_pass = p;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({unlocked, alarm, pass_changed, fail_cnt, digit_idx, lock_level} !== 10'd0) begin failures++; $display("FAIL reset_outputs got=%b exp=0", {unlocked, alarm, pass_changed, fail_cnt, digit_idx, lock_level}); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({unlocked, alarm, fail_cnt, digit_idx} !== 7'd0) begin failures++; $display("FAIL after_release got=%b exp=0", {unlocked, alarm, fail_cnt, digit_idx}); end
  endtask

  task automatic test_unlock();
    unlock_correct();
    relock();
  endtask

  task automatic test_lockout_escalation();
    logic [15:0] w;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < MAX_TRIES; k++) begin
        w = wrong_code();
        enter_code(w);
        finish_entry(w);
      end
    unlock_correct();
    relock();
  endtask

  task automatic test_timeout();
    logic [15:0] w;
    w = wrong_code();
    enter_code(w);
    finish_entry(w);
    press(4'd1, 1'b0, 1);
    press(4'd2, 1'b0, 1);
    repeat (TIMEOUT_CYCLES-1) @(negedge clk);
    checks++; if (digit_idx !== 3'd2) begin failures++; $display("FAIL timeout_early got=%0d exp=2", digit_idx); end
    @(negedge clk);
    checks++; if (digit_idx !== 3'd0) begin failures++; $display("FAIL timeout_discard got=%0d exp=0", digit_idx); end
    checks++; if (fail_cnt !== 2'(m_fail)) begin failures++; $display("FAIL timeout_fail_cnt got=%0d exp=%0d", fail_cnt, m_fail); end
    unlock_correct();
    press(4'd5, 1'b1, 1);
    press(4'd3, 1'b0, 1);
    press(4'd7, 1'b0, 1);
    repeat (TIMEOUT_CYCLES-1) @(negedge clk);
    checks++; if (unlocked !== 1'b0 || digit_idx !== 3'd2) begin failures++; $display("FAIL prog_timeout_early got=%0b/%0d exp=0/2", unlocked, digit_idx); end
    @(negedge clk);
    checks++; if (unlocked !== 1'b1 || digit_idx !== 3'd0) begin failures++; $display("FAIL prog_timeout_back got=%0b/%0d exp=1/0", unlocked, digit_idx); end
    relock();
    unlock_correct();
    relock();
  endtask

  task automatic test_hold_invalid();
    press(4'd1, 1'b0, 20);
    checks++; if (digit_idx !== 3'd1) begin failures++; $display("FAIL held_enter got=%0d exp=1", digit_idx); end
    press(4'hA, 1'b0, 1);
    checks++; if (digit_idx !== 3'd1) begin failures++; $display("FAIL invalid_digit got=%0d exp=1", digit_idx); end
    press(4'd2, 1'b0, 1);
    press(4'd3, 1'b0, 1);
    press(4'd4, 1'b0, 1);
    finish_entry(16'h1234);
    relock();
    press(4'd1, 1'b0, 1);
    repeat (29) @(negedge clk);
    press(4'hF, 1'b0, 1);
    repeat (18) @(negedge clk);
    checks++; if (digit_idx !== 3'd1) begin failures++; $display("FAIL invalid_no_restart_early got=%0d exp=1", digit_idx); end
    @(negedge clk);
    checks++; if (digit_idx !== 3'd0) begin failures++; $display("FAIL invalid_no_restart got=%0d exp=0", digit_idx); end
  endtask

  task automatic test_prog();
    unlock_correct();
    program_pass(16'h9876);
    enter_code(16'h1234);
    finish_entry(16'h1234);
    enter_code(16'h9876);
    finish_entry(16'h9876);
    relock();
  endtask

  task automatic test_reset_mid();
    logic [15:0] w;
    for (int k = 0; k < MAX_TRIES-1; k++) begin
      w = wrong_code();
      enter_code(w);
      finish_entry(w);
    end
    w = wrong_code();
    enter_code(w);
    @(negedge clk);
    checks++; if (alarm !== 1'b1) begin failures++; $display("FAIL lockout_entered got=%0b exp=1", alarm); end
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({alarm, unlocked, fail_cnt, lock_level} !== 6'd0) begin failures++; $display("FAIL reset_in_lockout got=%b exp=0", {alarm, unlocked, fail_cnt, lock_level}); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    m_pass = 16'h1234;
    m_fail = 0;
    m_level = 0;
    unlock_correct();
    program_pass(wrong_code());
    unlock_correct();
    press(4'($urandom_range(0, 9)), 1'b1, 1);
    press(4'd3, 1'b0, 1);
    press(4'd8, 1'b0, 1);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({unlocked, alarm, pass_changed, digit_idx} !== 6'd0) begin failures++; $display("FAIL reset_in_prog got=%b exp=0", {unlocked, alarm, pass_changed, digit_idx}); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    m_pass = 16'h1234;
    m_fail = 0;
    m_level = 0;
    unlock_correct();
    relock();
  endtask

  task automatic test_random();
    logic [15:0] w;
    for (int t = 0; t < 25; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        unlock_correct();
        if ($urandom_range(0, 1) == 1) program_pass(rand_code());
        else relock();
      end else begin
        w = wrong_code();
        enter_code(w);
        finish_entry(w);
      end
    end
  endtask

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_unlock();
    test_lockout_escalation();
    test_timeout();
    test_hold_invalid();
    test_prog();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
